// File: rtl/apb_write_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_write_pkg
//  Purpose  : Shared types and helpers for the APB write requester path.
//  Revision : 1.0  initial release
// ============================================================================
package apb_write_pkg;

  // Default APB address and data widths
  localparam int APB_ADDR_W_DEF = 32;
  localparam int APB_DATA_W_DEF = 32;

  // Requester transfer phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_wr_state_e;

  // Width needed to count 0..timeout; never narrower than one bit
  function automatic int wait_cnt_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return ($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage : apb_write_pkg
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_wait_timer
//  Purpose  : Saturating responder wait-state counter. Flags when TIMEOUT
//             wait cycles have been counted. TIMEOUT of 0 never expires.
//  Revision : 1.0  initial release
// ============================================================================
module apb_wait_timer
  import apb_write_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int            CNT_W = wait_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count ticks and hold at all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != SAT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_write_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_write_master
//  Purpose  : APB write requester. Accepts one word-write command at a time
//             on a valid/ready port, runs SETUP/ACCESS on APB, tolerates
//             responder wait states and aborts after TIMEOUT waits.
//  Revision : 1.0  initial release
// ============================================================================
module apb_write_master
  import apb_write_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W_DEF,
  parameter int DATA_W  = APB_DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              done,
  output logic              err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY
);

  apb_wr_state_e     state_q,     state_d;
  logic              req_ready_q, req_ready_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;

  logic              timer_clear;
  logic              timer_tick;
  logic              timer_expired;
  logic [ADDR_W-1:0] addr_aligned;

  // APB only carries whole words here, so the byte offset is dropped
  assign addr_aligned = req_addr & ~ADDR_W'(3);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // Next-state and next-output decode; outputs follow the state being entered
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    timer_clear = 1'b0;
    timer_tick  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          paddr_d     = addr_aligned;
          pwdata_d    = req_data;
          timer_clear = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completing responder beats a simultaneous timeout
        if (PREADY) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_tick = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
    pwrite_d    = psel_d;
    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset drops the bus and loses any command
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule : apb_write_master
`default_nettype wire

// File: tb/tb_apb_write_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_write_master
//  Purpose  : Directed, self-checking bench for apb_write_master with a
//             small APB responder memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_write_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          done;
  logic          err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  apb_write_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Responder memory: a write lands on the ACCESS edge that sees PREADY
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PWRITE && PREADY) begin
      mem[PADDR[7:2]] <= PWDATA;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic [31:0] exp_paddr;
    int          exp_acc;
    int          exp_idx;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      step();
      k++;
    end
    chk("ready_before_cmd", 64'(req_ready), 64'(1));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int waits,
                          input logic [31:0] exp_paddr, input int exp_acc, input int idx);
    int   n;
    logic stable;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    step();
    req_valid = 1'b0;
    chk("setup_ctrl", 64'({PSEL, PENABLE, PWRITE, req_ready}), 64'(4'b1010));
    chk("setup_paddr", 64'(PADDR), 64'(exp_paddr));
    chk("setup_pwdata", 64'(PWDATA), 64'(data));
    PREADY = 1'b1;
    n = 0;
    stable = 1'b1;
    step();
    while (PSEL && PENABLE && n < 64) begin
      n++;
      if (PADDR !== exp_paddr || PWDATA !== data || PWRITE !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
      PREADY = (n == waits + 1);
      step();
    end
    PREADY = 1'b0;
    chk("access_cycles", 64'(n), 64'(exp_acc));
    chk("access_stable", 64'(stable), 64'(1));
    chk("done_cycle", 64'({done, err, PSEL, req_ready}), 64'(4'b1001));
    step();
    chk("done_one_cycle", 64'({done, err}), 64'(0));
    chk("mem_word", 64'(mem[idx]), 64'(data));
  endtask

  initial begin
    int   n;
    int   k;
    int   idx;
    int   cyc;
    int   dcount;
    int   last;
    logic gap_ok;
    logic stable;
    logic hs;
    logic saw_pulse;

    vecs[0] = '{addr: 32'h0000_0013, data: 32'hDEAD_BEEF, waits: 0,  exp_paddr: 32'h0000_0010, exp_acc: 1,  exp_idx: 4};
    vecs[1] = '{addr: 32'h0000_0040, data: 32'h1234_5678, waits: 3,  exp_paddr: 32'h0000_0040, exp_acc: 4,  exp_idx: 16};
    vecs[2] = '{addr: 32'h0000_0027, data: 32'hA5A5_5A5A, waits: 1,  exp_paddr: 32'h0000_0024, exp_acc: 2,  exp_idx: 9};
    vecs[3] = '{addr: 32'h0000_00FE, data: 32'h0000_0000, waits: 15, exp_paddr: 32'h0000_00FC, exp_acc: 16, exp_idx: 63};

    // Reset values
    step();
    step();
    chk("reset_ctrl", 64'({req_ready, done, err, PSEL, PENABLE, PWRITE}), 64'(0));
    chk("reset_paddr", 64'(PADDR), 64'(0));
    chk("reset_pwdata", 64'(PWDATA), 64'(0));
    PRESET = 1'b0;
    chk("ready_at_release", 64'(req_ready), 64'(0));
    step();
    chk("ready_after_release", 64'(req_ready), 64'(1));

    // Table-driven single writes
    for (int i = 0; i < 4; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].exp_paddr, vecs[i].exp_acc, vecs[i].exp_idx);
    end

    // Wait states with a second command held pending throughout
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_data  = 32'h1234_5678;
    PREADY    = 1'b1;
    step();
    req_addr  = 32'h0000_0044;
    req_data  = 32'hCAFE_0001;
    chk("pend_setup_paddr", 64'(PADDR), 64'(32'h40));
    PREADY = 1'b0;
    n = 0;
    stable = 1'b1;
    step();
    while (PSEL && PENABLE && n < 64) begin
      n++;
      if (PADDR !== 32'h40 || PWDATA !== 32'h1234_5678 || req_ready !== 1'b0) stable = 1'b0;
      PREADY = (n == 4);
      step();
    end
    PREADY = 1'b0;
    chk("pend_access_cycles", 64'(n), 64'(4));
    chk("pend_stable", 64'(stable), 64'(1));
    chk("pend_done_ready", 64'({done, req_ready}), 64'(2'b11));
    step();
    req_valid = 1'b0;
    chk("pend_b_setup", 64'({PSEL, PENABLE, PADDR}), 64'({2'b10, 32'h44}));
    PREADY = 1'b1;
    k = 0;
    while (!done && k < 10) begin
      step();
      k++;
    end
    chk("pend_b_done", 64'(done), 64'(1));
    PREADY = 1'b0;
    step();
    chk("pend_mem_a", 64'(mem[16]), 64'(32'h1234_5678));
    chk("pend_mem_b", 64'(mem[17]), 64'(32'hCAFE_0001));

    // Back-to-back commands with PREADY held high
    wait_ready();
    PREADY    = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    req_data  = 32'd1;
    idx = 0;
    cyc = 0;
    dcount = 0;
    last = -1;
    gap_ok = 1'b1;
    while (cyc < 40 && dcount < 4) begin
      hs = req_valid && req_ready;
      step();
      cyc++;
      if (hs) begin
        idx++;
        if (idx < 4) begin
          req_addr = 32'(idx * 4);
          req_data = 32'(idx + 1);
        end else begin
          req_valid = 1'b0;
        end
      end
      if (done) begin
        if (last >= 0 && (cyc - last) != 3) gap_ok = 1'b0;
        last = cyc;
        dcount++;
      end
    end
    PREADY = 1'b0;
    req_valid = 1'b0;
    chk("b2b_done_count", 64'(dcount), 64'(4));
    chk("b2b_period", 64'(gap_ok), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("b2b_mem", 64'(mem[i]), 64'(i + 1));
    end

    // Timeout with PREADY held low
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0008;
    req_data  = 32'h5555_5555;
    step();
    req_valid = 1'b0;
    PREADY = 1'b0;
    n = 0;
    step();
    while (PSEL && n < 64) begin
      n++;
      step();
    end
    chk("to_access_cycles", 64'(n), 64'(TO + 1));
    chk("to_err_pulse", 64'({done, err, PENABLE, req_ready}), 64'(4'b0101));
    step();
    chk("to_err_one_cycle", 64'({done, err}), 64'(0));
    chk("to_no_write", 64'(mem[2]), 64'(3));

    // PREADY on exactly the timeout edge: completion wins
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_00C4;
    req_data  = 32'h0BAD_F00D;
    step();
    req_valid = 1'b0;
    n = 0;
    step();
    while (PSEL && n < 64) begin
      n++;
      PREADY = (n == TO + 1);
      step();
    end
    PREADY = 1'b0;
    chk("prec_access_cycles", 64'(n), 64'(TO + 1));
    chk("prec_done_not_err", 64'({done, err}), 64'(2'b10));
    chk("prec_mem", 64'(mem[49]), 64'(32'h0BAD_F00D));

    // Reset in the middle of ACCESS
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0020;
    req_data  = 32'h7777_7777;
    step();
    req_valid = 1'b0;
    PREADY = 1'b0;
    step();
    step();
    step();
    chk("rst_mid_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    #2;
    PRESET = 1'b1;
    #1;
    chk("rst_mid_bus_drop", 64'({PSEL, PENABLE, req_ready}), 64'(0));
    saw_pulse = 1'b0;
    step();
    if (done || err) saw_pulse = 1'b1;
    PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || err) saw_pulse = 1'b1;
    end
    chk("rst_mid_no_pulse", 64'(saw_pulse), 64'(0));
    chk("rst_mid_idle", 64'({PSEL, PENABLE, req_ready}), 64'(3'b001));
    do_write(32'h0000_0022, 32'h9999_0000, 2, 32'h0000_0020, 3, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_apb_write_master
`default_nettype wire
